// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI memory controller slice:
//   - spi_cmd_e  : two-bit command opcode carried in the top bits of a frame
//   - rd_state_e : encoding of the read-side state machine
//   - hold_cnt_width() : width needed for the HOLD down-counter
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,   // payload -> write address register
        CMD_WR_DATA = 2'b01,   // payload -> mem[write address]
        CMD_RD_ADDR = 2'b10,   // payload -> read address register
        CMD_RD_DATA = 2'b11    // start a read of mem[read address]
    } spi_cmd_e;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'b00,
        RD_FETCH = 2'b01,
        RD_HOLD  = 2'b10
    } rd_state_e;

    // The HOLD counter has to represent the value addr_size itself.
    function automatic int hold_cnt_width(input int addr_size);
        return $clog2(addr_size + 1);
    endfunction

endpackage

// File: rtl/spi_mem_array.sv
// -----------------------------------------------------------------------------
// spi_mem_array
// Register array used as the controller's storage. One write port and one
// registered read port sharing a single clock. Array contents are never
// reset; only the read-data register is.
//
// Ports:
//   clk      in   clock, all state updates on the rising edge
//   rst_n    in   asynchronous active-low reset (read register only)
//   wr_en    in   write strobe, mem[wr_addr] <= wr_data on this edge
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe, rd_data <= mem[rd_addr] on this edge
//   rd_addr  in   read address
//   rd_data  out  registered read data, holds until the next rd_en
// -----------------------------------------------------------------------------
module spi_mem_array #(
    parameter int  DEPTH = 256,
    parameter int  WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;

    // Storage has no reset so it survives a controller reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // A read and a write on the same edge to the same address return the
    // old contents (read-before-write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem_reg[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/spi_mem_ctrl.sv
// -----------------------------------------------------------------------------
// spi_mem_ctrl
// Command decoder and read sequencer sitting between an SPI slave and a small
// memory. Each accepted frame carries a 2-bit opcode and an ADDR_SIZE-bit
// payload (address and data share the same width):
//   00 load write address, 01 write payload, 10 load read address, 11 read.
// A read walks IDLE -> FETCH -> HOLD; the word is presented on tx_data with
// tx_valid high for ADDR_SIZE cycles, and tx_data keeps the word afterwards.
//
// Build option: define SPI_MEM_AUTOINC_EN to auto-increment the write address
// after every write and the read address after every FETCH; in that build
// the missing-read-address error is suppressed once any read address has
// been loaded.
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   rx_data   in   frame: [ADDR_SIZE+1:ADDR_SIZE] opcode, [ADDR_SIZE-1:0] payload
//   rx_valid  in   frame accepted on every rising edge where this is 1
//   tx_data   out  read word
//   tx_valid  out  tx_data qualifier
//   cmd_err   out  one-cycle pulse: read issued with no fresh read address
// -----------------------------------------------------------------------------
module spi_mem_ctrl #(
    parameter int  MEM_DEPTH = 256,
    localparam int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] rx_data,
    input  logic                 rx_valid,
    output logic [ADDR_SIZE-1:0] tx_data,
    output logic                 tx_valid,
    output logic                 cmd_err
);

    import spi_pkg::*;

    localparam int CNT_W = hold_cnt_width(ADDR_SIZE);

    localparam logic [1:0] IDLE  = RD_IDLE;
    localparam logic [1:0] FETCH = RD_FETCH;
    localparam logic [1:0] HOLD  = RD_HOLD;

    // ---------------------------------------------------------------------
    // Frame decode
    // ---------------------------------------------------------------------
    spi_cmd_e             cmd;
    logic [ADDR_SIZE-1:0] payload;
    logic                 do_wr_addr;
    logic                 do_wr_data;
    logic                 do_rd_addr;
    logic                 do_rd_data;

    assign cmd        = spi_cmd_e'(rx_data[ADDR_SIZE+1:ADDR_SIZE]);
    assign payload    = rx_data[ADDR_SIZE-1:0];
    assign do_wr_addr = rx_valid && (cmd == CMD_WR_ADDR);
    assign do_wr_data = rx_valid && (cmd == CMD_WR_DATA);
    assign do_rd_addr = rx_valid && (cmd == CMD_RD_ADDR);
    assign do_rd_data = rx_valid && (cmd == CMD_RD_DATA);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [1:0]           state_reg,      state_next;
    logic [CNT_W-1:0]     hold_cnt_reg,   hold_cnt_next;
    logic [ADDR_SIZE-1:0] wr_addr_reg,    wr_addr_next;
    logic [ADDR_SIZE-1:0] rd_addr_reg,    rd_addr_next;
    logic                 tx_valid_reg,   tx_valid_next;
    logic                 cmd_err_reg,    cmd_err_next;
    logic                 rd_pending_reg, rd_pending_next;
    logic                 rd_missing;
`ifdef SPI_MEM_AUTOINC_EN
    logic                 rd_seen_reg,    rd_seen_next;
`endif

    // A read is flagged when no read address was loaded since reset or
    // since the previous read.
`ifdef SPI_MEM_AUTOINC_EN
    assign rd_missing = !rd_pending_reg && !rd_seen_reg;
`else
    assign rd_missing = !rd_pending_reg;
`endif

    always_comb begin
        state_next      = state_reg;
        hold_cnt_next   = hold_cnt_reg;
        tx_valid_next   = tx_valid_reg;
        wr_addr_next    = wr_addr_reg;
        rd_addr_next    = rd_addr_reg;
        rd_pending_next = rd_pending_reg;
        cmd_err_next    = 1'b0;
`ifdef SPI_MEM_AUTOINC_EN
        rd_seen_next    = rd_seen_reg;
`endif

        // Read sequencer
        case (state_reg)
            IDLE: begin
                tx_valid_next = 1'b0;
            end
            FETCH: begin
                // The array captures mem[rd_addr] on this edge.
                state_next    = HOLD;
                tx_valid_next = 1'b1;
                hold_cnt_next = CNT_W'(ADDR_SIZE);
            end
            HOLD: begin
                // Counter runs ADDR_SIZE..1 while valid; the edge that
                // takes it to 0 also returns to IDLE.
                if (hold_cnt_reg <= CNT_W'(1)) begin
                    state_next    = IDLE;
                    tx_valid_next = 1'b0;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                tx_valid_next = 1'b0;
                hold_cnt_next = '0;
            end
        endcase

        // A read command from any state (re)starts the fetch.
        if (do_rd_data) begin
            state_next    = FETCH;
            tx_valid_next = 1'b0;
            hold_cnt_next = '0;
            cmd_err_next  = rd_missing;
        end

        // Address registers
        if (do_wr_addr) begin
            wr_addr_next = payload;
        end
`ifdef SPI_MEM_AUTOINC_EN
        else if (do_wr_data) begin
            wr_addr_next = wr_addr_reg + ADDR_SIZE'(1);
        end
`endif

        if (do_rd_addr) begin
            rd_addr_next = payload;
        end
`ifdef SPI_MEM_AUTOINC_EN
        else if (state_reg == FETCH) begin
            rd_addr_next = rd_addr_reg + ADDR_SIZE'(1);
        end
`endif

        // Fresh-read-address tracking
        if (do_rd_addr) begin
            rd_pending_next = 1'b1;
        end else if (do_rd_data) begin
            rd_pending_next = 1'b0;
        end
`ifdef SPI_MEM_AUTOINC_EN
        if (do_rd_addr) begin
            rd_seen_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            hold_cnt_reg   <= '0;
            wr_addr_reg    <= '0;
            rd_addr_reg    <= '0;
            tx_valid_reg   <= 1'b0;
            cmd_err_reg    <= 1'b0;
            rd_pending_reg <= 1'b0;
`ifdef SPI_MEM_AUTOINC_EN
            rd_seen_reg    <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            hold_cnt_reg   <= hold_cnt_next;
            wr_addr_reg    <= wr_addr_next;
            rd_addr_reg    <= rd_addr_next;
            tx_valid_reg   <= tx_valid_next;
            cmd_err_reg    <= cmd_err_next;
            rd_pending_reg <= rd_pending_next;
`ifdef SPI_MEM_AUTOINC_EN
            rd_seen_reg    <= rd_seen_next;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Storage: writes land on the accepting edge, reads register in FETCH
    // and the read register itself drives tx_data.
    // ---------------------------------------------------------------------
    spi_mem_array #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (ADDR_SIZE)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (do_wr_data),
        .wr_addr (wr_addr_reg),
        .wr_data (payload),
        .rd_en   (state_reg == FETCH),
        .rd_addr (rd_addr_reg),
        .rd_data (tx_data)
    );

    assign tx_valid = tx_valid_reg;
    assign cmd_err  = cmd_err_reg;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_ctrl
// Directed bench for spi_mem_ctrl (MEM_DEPTH = 256, 8-bit words). Each read
// command pushes its expected word onto a queue; a monitor pops and compares
// on every rising tx_valid and checks tx_data stays put while tx_valid is high.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_spi_mem_ctrl;

    localparam int MEM_DEPTH = 256;
    localparam int AW        = 8;

    logic          clk;
    logic          rst_n;
    logic [AW+1:0] rx_data;
    logic          rx_valid;
    logic [AW-1:0] tx_data;
    logic          tx_valid;
    logic          cmd_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] exp_q [$];
    logic          prev_valid = 1'b0;
    logic [AW-1:0] held_word  = '0;

    spi_mem_ctrl #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .cmd_err  (cmd_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (tx_valid && !prev_valid) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_read: observed tx_valid rise with %0d queued, expected >0", exp_q.size());
            end
            if (exp_q.size() != 0) begin
                check("read_data", 16'(tx_data), 16'(exp_q.pop_front()));
                $display("read word %02h", tx_data);
            end
        end else if (tx_valid && prev_valid) begin
            check("hold_stable", 16'(tx_data), 16'(held_word));
        end
        held_word  <= tx_data;
        prev_valid <= tx_valid;
    end

    task automatic frame(input logic [1:0] op, input logic [AW-1:0] pl);
        rx_data  = {op, pl};
        rx_valid = 1'b1;
        @(negedge clk);
        $display("frame op=%0b payload=%02h", op, pl);
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        rx_data  = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_tx_valid", 16'(tx_valid), 16'h0);
        check("rst_tx_data",  16'(tx_data),  16'h0);
        check("rst_cmd_err",  16'(cmd_err),  16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);
    endtask

    // Called on the falling edge right after the read frame was accepted:
    // FETCH cycle now, HOLD after the next edge.
    task automatic expect_rise(input string tag);
        check({tag, "_fetch_valid"}, 16'(tx_valid), 16'h0);
        @(negedge clk);
        check({tag, "_rise_valid"}, 16'(tx_valid), 16'h1);
        check({tag, "_err_cleared"}, 16'(cmd_err), 16'h0);
    endtask

    // Counts remaining HOLD cycles; 'already' HOLD cycles were seen so far.
    task automatic finish_hold(input string tag, input int already, input logic [AW-1:0] word);
        int n;
        n = already;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!tx_valid) break;
            n++;
        end
        check({tag, "_hold_len"}, 16'(n), 16'd8);
        check({tag, "_retain"}, 16'(tx_data), 16'(word));
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        @(negedge clk);
        do_reset();

`ifdef SPI_MEM_AUTOINC_EN
        frame(2'b00, 8'hFF);
        frame(2'b01, 8'h11);
        frame(2'b01, 8'h22);
        frame(2'b10, 8'hFF);
        exp_q.push_back(8'h11);
        frame(2'b11, 8'h00);
        check("ai_err0", 16'(cmd_err), 16'h0);
        expect_rise("ai_rd_ff");
        finish_hold("ai_rd_ff", 1, 8'h11);
        // read address advanced to 0x00; error check now disabled
        exp_q.push_back(8'h22);
        frame(2'b11, 8'h00);
        check("ai_err1", 16'(cmd_err), 16'h0);
        expect_rise("ai_rd_00");
        finish_hold("ai_rd_00", 1, 8'h22);
`else
        // Write with no prior address load goes to address 0.
        frame(2'b01, 8'h5A);
        check("wr_no_addr_err", 16'(cmd_err), 16'h0);
        do_reset();

        // Read straight after reset: error pulse, still reads mem[0].
        exp_q.push_back(8'h5A);
        frame(2'b11, 8'h00);
        check("rd_after_rst_err", 16'(cmd_err), 16'h1);
        expect_rise("rd_after_rst");
        finish_hold("rd_after_rst", 1, 8'h5A);

        // Basic write/read, read address loaded on the frame just before.
        frame(2'b00, 8'h10);
        frame(2'b01, 8'hA5);
        frame(2'b10, 8'h10);
        exp_q.push_back(8'hA5);
        frame(2'b11, 8'h00);
        check("basic_err", 16'(cmd_err), 16'h0);
        expect_rise("basic");
        finish_hold("basic", 1, 8'hA5);

        // Restart during HOLD: second read without a new address flags error.
        frame(2'b10, 8'h10);
        exp_q.push_back(8'hA5);
        frame(2'b11, 8'h00);
        check("restart_err0", 16'(cmd_err), 16'h0);
        expect_rise("restart_first");
        idle(2);
        exp_q.push_back(8'hA5);
        frame(2'b11, 8'h00);
        check("restart_err1", 16'(cmd_err), 16'h1);
        expect_rise("restart_second");
        finish_hold("restart_second", 1, 8'hA5);

        // Address load and write during HOLD leave the read untouched.
        frame(2'b10, 8'h10);
        exp_q.push_back(8'hA5);
        frame(2'b11, 8'h00);
        expect_rise("wr_in_hold");
        frame(2'b00, 8'h20);
        frame(2'b01, 8'h3C);
        finish_hold("wr_in_hold", 3, 8'hA5);
        frame(2'b10, 8'h20);
        exp_q.push_back(8'h3C);
        frame(2'b11, 8'h00);
        check("rd_3c_err", 16'(cmd_err), 16'h0);
        expect_rise("rd_3c");
        finish_hold("rd_3c", 1, 8'h3C);

        // Reset in the third HOLD cycle.
        frame(2'b10, 8'h10);
        exp_q.push_back(8'hA5);
        frame(2'b11, 8'h00);
        expect_rise("rst_in_hold");
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        check("async_drop_valid", 16'(tx_valid), 16'h0);
        check("async_drop_data",  16'(tx_data),  16'h0);
        check("async_drop_err",   16'(cmd_err),  16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        check("no_resume", 16'(tx_valid), 16'h0);

        // Read address and pending flag cleared: reads mem[0] with error.
        exp_q.push_back(8'h5A);
        frame(2'b11, 8'h00);
        check("post_rst_err", 16'(cmd_err), 16'h1);
        expect_rise("post_rst_rd0");
        finish_hold("post_rst_rd0", 1, 8'h5A);

        // Memory kept its contents across reset.
        frame(2'b10, 8'h10);
        exp_q.push_back(8'hA5);
        frame(2'b11, 8'h00);
        check("mem_keep_err", 16'(cmd_err), 16'h0);
        expect_rise("mem_keep");
        finish_hold("mem_keep", 1, 8'hA5);

        // Write address cleared by reset.
        frame(2'b01, 8'h77);
        frame(2'b10, 8'h00);
        exp_q.push_back(8'h77);
        frame(2'b11, 8'h00);
        expect_rise("wr_addr_rst");
        finish_hold("wr_addr_rst", 1, 8'h77);
`endif

        idle(2);
        check("queue_empty", 16'(exp_q.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
